// File: rtl/qam_pkg.sv
// Shared definitions for the qam_mapper constellation mapper: modulation codes,
// coded bits per subcarrier and 8-bit Gray-mapped axis levels (1.0 = 64).
package qam_pkg;

  typedef enum logic [1:0] {
    MT_BPSK  = 2'b00,
    MT_QPSK  = 2'b01,
    MT_16QAM = 2'b10,
    MT_64QAM = 2'b11
  } map_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam int MAX_BPSC = 6;

  localparam logic signed [7:0] LVL_BPSK = 8'sd64;
  localparam logic signed [7:0] LVL_QPSK = 8'sd45;
  localparam logic signed [7:0] LVL_16_1 = 8'sd20;
  localparam logic signed [7:0] LVL_16_3 = 8'sd61;
  localparam logic signed [7:0] LVL_64_1 = 8'sd10;
  localparam logic signed [7:0] LVL_64_3 = 8'sd30;
  localparam logic signed [7:0] LVL_64_5 = 8'sd49;
  localparam logic signed [7:0] LVL_64_7 = 8'sd69;

  function automatic logic [2:0] n_bpsc(input map_type_e t);
    case (t)
      MT_BPSK:  return 3'd1;
      MT_QPSK:  return 3'd2;
      MT_16QAM: return 3'd4;
      default:  return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/qam_mapper_if.sv
// Serial coded-bit input and mapped I/Q sample output bundle of qam_mapper.
// map_err is present only when QAM_MAP_ERR_CHK_EN is defined.
interface qam_mapper_if #(
  parameter int OUT_W = 8
);
  logic [1:0]              map_type;
  logic                    map_din;
  logic                    map_din_vld;
  logic signed [OUT_W-1:0] map_i;
  logic signed [OUT_W-1:0] map_q;
  logic                    map_vld;
  logic [5:0]              map_idx;
  logic                    map_last;
`ifdef QAM_MAP_ERR_CHK_EN
  logic                    map_err;
`endif

  // Upstream side: feeds bits and consumes samples.
  modport master (
`ifdef QAM_MAP_ERR_CHK_EN
    input  map_err,
`endif
    output map_type, map_din, map_din_vld,
    input  map_i, map_q, map_vld, map_idx, map_last
  );

  // Mapper side.
  modport slave (
`ifdef QAM_MAP_ERR_CHK_EN
    output map_err,
`endif
    input  map_type, map_din, map_din_vld,
    output map_i, map_q, map_vld, map_idx, map_last
  );

endinterface

// File: rtl/qam_level_lut.sv
// Combinational Gray-coded axis level lookup: first bit is the sign, the rest
// select the magnitude. Output is the 8-bit normalised level.
module qam_level_lut
  import qam_pkg::*;
(
  input  map_type_e         type_i,
  input  logic [2:0]        bits_i,
  output logic signed [7:0] lvl_o
);

  logic signed [7:0] mag;

  always_comb begin
    mag = '0;
    case (type_i)
      MT_BPSK:  mag = LVL_BPSK;
      MT_QPSK:  mag = LVL_QPSK;
      MT_16QAM: mag = bits_i[1] ? LVL_16_1 : LVL_16_3;
      default: begin
        // {b1,b2}: 00 -> 7, 01 -> 5, 11 -> 3, 10 -> 1
        case ({bits_i[1], bits_i[2]})
          2'b00:   mag = LVL_64_7;
          2'b01:   mag = LVL_64_5;
          2'b11:   mag = LVL_64_3;
          default: mag = LVL_64_1;
        endcase
      end
    endcase
    lvl_o = bits_i[0] ? mag : -mag;
  end

endmodule

// File: rtl/qam_mapper.sv
// OFDM constellation mapper: groups 1/2/4/6 serial bits into one Gray-coded
// I/Q sample per subcarrier. Define QAM_MAP_ERR_CHK_EN to add sticky map_err.
module qam_mapper
  import qam_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int N_SC  = 48
) (
  input logic         cb_clk,
  input logic         rst,
  qam_mapper_if.slave bus
);

  localparam logic [5:0] SC_LAST = 6'(N_SC - 1);

  state_e                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [5:0]              sc_cnt_q, sc_cnt_d;
  logic [MAX_BPSC-1:0]     shift_q, shift_d;
  map_type_e               type_q, type_d;
  logic signed [OUT_W-1:0] map_i_q, map_i_d;
  logic signed [OUT_W-1:0] map_q_q, map_q_d;
  logic                    map_vld_q, map_vld_d;
  logic [5:0]              map_idx_q, map_idx_d;
  logic                    map_last_q, map_last_d;

  logic                    first_of_sym;
  map_type_e               eff_type;
  logic [MAX_BPSC-1:0]     grp_bits;
  logic                    grp_done;
  logic [2:0]              i_bits, q_bits;
  logic signed [7:0]       i_lvl, q_lvl;

  function automatic logic signed [OUT_W-1:0] scale_lvl(input logic signed [7:0] lvl);
    logic signed [OUT_W-1:0] ext;
    ext = OUT_W'(lvl);
    return ext <<< (OUT_W - 8);
  endfunction

  // The modulation is only sampled on the first bit of an OFDM symbol.
  assign first_of_sym = (bit_cnt_q == 3'd0) && (sc_cnt_q == 6'd0);
  assign eff_type     = first_of_sym ? map_type_e'(bus.map_type) : type_q;
  assign grp_done     = bus.map_din_vld && (bit_cnt_q == n_bpsc(eff_type) - 3'd1);

  always_comb begin
    grp_bits           = shift_q;
    grp_bits[bit_cnt_q] = bus.map_din;
  end

  assign i_bits = grp_bits[2:0];

  always_comb begin
    q_bits = '0;
    case (eff_type)
      MT_QPSK:  q_bits = {2'b00, grp_bits[1]};
      MT_16QAM: q_bits = {1'b0, grp_bits[3:2]};
      MT_64QAM: q_bits = grp_bits[5:3];
      default:  q_bits = '0;
    endcase
  end

  qam_level_lut u_lut_i (
    .type_i (eff_type),
    .bits_i (i_bits),
    .lvl_o  (i_lvl)
  );

  qam_level_lut u_lut_q (
    .type_i (eff_type),
    .bits_i (q_bits),
    .lvl_o  (q_lvl)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sc_cnt_d   = sc_cnt_q;
    shift_d    = shift_q;
    type_d     = type_q;
    map_i_d    = map_i_q;
    map_q_d    = map_q_q;
    map_vld_d  = 1'b0;
    map_idx_d  = map_idx_q;
    map_last_d = 1'b0;

    if (bus.map_din_vld) begin
      type_d = eff_type;
      if (grp_done) begin
        bit_cnt_d  = '0;
        shift_d    = '0;
        map_vld_d  = 1'b1;
        map_i_d    = scale_lvl(i_lvl);
        map_q_d    = (eff_type == MT_BPSK) ? '0 : scale_lvl(q_lvl);
        map_idx_d  = sc_cnt_q;
        map_last_d = (sc_cnt_q == SC_LAST);
        sc_cnt_d   = (sc_cnt_q == SC_LAST) ? 6'd0 : sc_cnt_q + 6'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = grp_bits;
      end
    end

    // COLLECT means a partial group is held; a back-to-back group re-enters it.
    case (state_q)
      ST_IDLE:    if (bus.map_din_vld && !grp_done) state_d = ST_COLLECT;
      ST_COLLECT: if (grp_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cb_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sc_cnt_q   <= '0;
      shift_q    <= '0;
      type_q     <= MT_BPSK;
      map_i_q    <= '0;
      map_q_q    <= '0;
      map_vld_q  <= 1'b0;
      map_idx_q  <= '0;
      map_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sc_cnt_q   <= sc_cnt_d;
      shift_q    <= shift_d;
      type_q     <= type_d;
      map_i_q    <= map_i_d;
      map_q_q    <= map_q_d;
      map_vld_q  <= map_vld_d;
      map_idx_q  <= map_idx_d;
      map_last_q <= map_last_d;
    end
  end

  assign bus.map_i    = map_i_q;
  assign bus.map_q    = map_q_q;
  assign bus.map_vld  = map_vld_q;
  assign bus.map_idx  = map_idx_q;
  assign bus.map_last = map_last_q;

`ifdef QAM_MAP_ERR_CHK_EN
  logic err_q, err_d;

  assign err_d = err_q | (bus.map_din_vld && !first_of_sym &&
                          (map_type_e'(bus.map_type) != type_q));

  always_ff @(posedge cb_clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.map_err = err_q;
`endif

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
Constellation mapper stage directly downstream of the data interleaver in the OFDM transmit chain. It takes the interleaver's serial bit stream (intv_dout/intv_vld) and its map_type, and groups 1/2/4/6 bits per subcarrier for BPSK/QPSK/16-QAM/64-QAM. It emits one Gray-coded, power-normalised I/Q sample per subcarrier, with a subcarrier index and an end-of-OFDM-symbol marker, to the pilot-insertion/IFFT front end.

Parameters:
OUT_W, 8, signed I/Q output width; must be >= 8. Package levels are defined for 8 bits and are left-shifted by OUT_W-8.
N_SC, 48, data subcarriers per OFDM symbol; sets map_idx wrap and map_last.

Ports:
cb_clk  in  1  80 MHz clock; single clock domain.
rst  in  1  reset; synchronous, active-high.
map_type  in  2  modulation: 00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM. Driven by data_interleaver.map_type.
map_din  in  1  serial coded bit (data_interleaver.intv_dout).
map_din_vld  in  1  map_din qualifier (data_interleaver.intv_vld); no backpressure.
map_i  out  OUT_W  in-phase sample, two's complement.
map_q  out  OUT_W  quadrature sample, two's complement.
map_vld  out  1  one-cycle strobe per mapped subcarrier.
map_idx  out  6  subcarrier index 0..N_SC-1 of the current sample.
map_last  out  1  high with map_vld on subcarrier N_SC-1.

Behaviour:
- Reset: map_i=0, map_q=0, map_vld=0, map_idx=0, map_last=0. Bit counter, subcarrier counter, shift register and latched type are all cleared.
- Reset asserted mid-group or mid-symbol discards partial bits. There is no output on the cycle after reset.
- FSM IDLE / COLLECT:
  - IDLE→COLLECT on map_din_vld; that bit is b0.
  - COLLECT→IDLE after the N_BPSC-th bit with no new valid in the same cycle.
  - COLLECT→COLLECT when a new group starts back-to-back.
- Bits are consumed only on map_din_vld. Gaps of any length between bits (e.g. SIGNAL field at 1 bit per 4 clocks) are legal and do not reset the group.
- N_BPSC is 1/2/4/6 per map_type.
- map_type latch point: latched into type_q when bit_cnt==0 and sc_cnt==0, i.e. the first bit of each OFDM symbol. It is held for all N_SC subcarriers; changes mid-symbol are ignored.
- Bit order is first-received = b0.
  - BPSK: I from b0; Q=0.
  - QPSK: I from b0, Q from b1.
  - 16-QAM: I from b0b1, Q from b2b3.
  - 64-QAM: I from b0b1b2, Q from b3b4b5.
- Gray maps (802.11a):
  - BPSK: 0→-1, 1→+1.
  - 16-QAM pair: 00→-3, 01→-1, 11→+1, 10→+3.
  - 64-QAM triple: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Scaled levels at OUT_W=8 (1.0 = 64):
  - BPSK: ±64.
  - QPSK: ±45.
  - 16-QAM: ±20, ±61.
  - 64-QAM: ±10, ±30, ±49, ±69.
- Latency: map_vld rises exactly 1 cycle after the cycle carrying the group's last valid bit, and lasts 1 cycle. map_i/map_q/map_idx are registered with it and hold until the next map_vld.
- sc_cnt increments on each map_vld and wraps N_SC-1→0. map_last = map_vld && sc_cnt==N_SC-1.
- Simultaneous events: output of group k and the first bit of group k+1 in the same cycle are both handled; throughput is 1 bit/clk sustained.

Optional Feature:
QAM_MAP_ERR_CHK_EN
- Defined: adds output map_err (1 bit, reset 0). It is sticky-set when map_type differs from type_q while sc_cnt!=0 or bit_cnt!=0 on a map_din_vld cycle, and is cleared only by rst.
- Undefined: the port is absent and mid-symbol type changes are silently ignored.

Decomposition:
- Package qam_pkg:
  - map_type encodings (MT_BPSK, MT_QPSK, MT_16QAM, MT_64QAM).
  - N_BPSC per type.
  - 8-bit level constants (LVL_BPSK=64, LVL_QPSK=45, LVL_16_1=20, LVL_16_3=61, LVL_64_1=10, LVL_64_3=30, LVL_64_5=49, LVL_64_7=69).
- Sub-module qam_level_lut: purely combinational; bits plus type → one signed axis level. Instantiated twice, for I and Q.

Test Plan:
1. BPSK, 48 bits alternating 1,0 -> map_i=+64,-64,... with map_q=0; map_idx 0..47; map_last only on idx 47; map_vld 1 cycle after each bit.
2. QPSK bits 1,0 -> map_i=+45, map_q=-45, one map_vld.
3. 16-QAM bits 1,0,0,1 with 3-idle-cycle gaps between bits -> map_i=+61, map_q=-20; map_vld 1 cycle after the 4th bit.
4. 64-QAM bits 0,1,0,1,1,1 -> map_i=-10, map_q=+30.
5. 64-QAM, continuous 288 bits -> exactly 48 map_vld pulses. Then map_type toggled to QPSK at subcarrier 20 of the next symbol -> mapping stays 64-QAM until idx 0; map_err=1 when QAM_MAP_ERR_CHK_EN is defined.
6. rst pulsed after 3 bits of a 16-QAM group -> all outputs 0; the next 4 bits form a fresh group at map_idx=0.
